ir_frame_decoder: RTL
=====================

Name: ir_frame_decoder

Overview:
- Receives the demodulated output of the IR receiver on the cart and decodes Samsung-format frames (leader, 32 data bits LSB-first, stop mark) into a 32-bit command word.
- Presents each decoded word to the cart control logic with a ready/ack handshake. That logic runs on a slow derived clock, so ack is asynchronous to clk.
- Sits between the IR receiver input pin and the control block. It is the producer of command/ir_ready and the consumer of ack.

Parameters:
- clk_hz, 25000000, system clock frequency in Hz.
- tick_us, 10, measurement tick period in microseconds. TICK_DIV = clk_hz*tick_us/1000000, minimum 1.
- ir_active_low, 1, ir_in polarity. 1 means a carrier mark is seen as 0 on the pin.
- timeout_ticks, 700, maximum length of any segment before the frame is aborted. 7 ms at default.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ir_in  in  1  raw IR receiver output, asynchronous
- ack  in  1  acknowledge from control, asynchronous level
- command  out  32  last accepted frame; first received bit is command[0]
- ir_ready  out  1  command valid, held until acknowledged
- frame_err  out  1  one-clk pulse when a malformed frame is discarded
- overrun  out  1  one-clk pulse when a good frame is dropped because ir_ready is still high
- busy  out  1  high while the FSM is not IDLE

Behaviour:
- Reset values: command=0, ir_ready=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, tick counter=0, bit counter=0, ack-seen flag=0.
- Input conditioning: ir_in and ack each pass through a 2-flop synchronizer. mark = synced ir_in XOR ir_active_low, i.e. mark is 1 while carrier is present.
- Tick generator: free-running, emits a one-clk tick every TICK_DIV clocks.
- Segment counter: counts ticks, clears on every change of mark, and saturates at timeout_ticks.
- Window limits, all in ticks at default:
  - leader mark: 360..540
  - leader space: 360..540
  - bit mark: 30..90
  - zero space: 30..90
  - one space: 120..230
  - stop mark: 30..90
- Every limit is derived from microsecond constants divided by tick_us.
- FSM:
  - IDLE: on a mark rising edge, go to LEAD_MARK.
  - LEAD_MARK: on mark falling, check the leader mark window, then go to LEAD_SPACE.
  - LEAD_SPACE: on mark rising, check the leader space window, then go to BIT_MARK.
  - BIT_MARK: on mark falling, check the bit mark window, then go to BIT_SPACE.
  - BIT_SPACE: on mark rising, classify the space as 0 or 1 and shift it in at position bitcnt. If bitcnt was 31, go to STOP_MARK; otherwise increment bitcnt and go to BIT_MARK.
  - STOP_MARK: on mark falling, check the stop mark window, then go to DONE.
  - DONE: lasts one clk. If ir_ready=0, load command from the shift register and set ir_ready. Otherwise pulse overrun and leave command unchanged. Return to IDLE.
- Errors: a failed window check, a space that is neither a 0 nor a 1, or the segment counter reaching timeout_ticks in any non-IDLE state causes a frame_err pulse, a shift register clear and a return to IDLE.
- Idle at power-up: the counter saturating while in IDLE is not an error.
- Handshake:
  - ir_ready clears on the first clk where synced ack=1, and the ack-seen flag is set.
  - ir_ready may be set again only after synced ack has returned to 0, which clears the flag.
  - A frame finishing while ack is still high counts as an overrun.
- Decode latency: ir_ready rises 3 clks after the stop-mark falling edge at the pin (2 sync + DONE).
- The FSM keeps decoding while ir_ready=1. Only the final load is suppressed.
- Reset mid-frame: all state returns to its reset value immediately. The partial frame is lost and no pulses are generated.

Optional Feature:
- IR_CHECK_EN defined: in DONE, require command byte [23:16] == ~[31:24]. On mismatch, pulse frame_err instead of loading or signalling overrun.
- IR_CHECK_EN undefined: no integrity check; all well-timed frames are accepted.

Decomposition:
- Package ir_pkg holds:
  - the state enum for IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, DONE
  - microsecond timing constants (leader, bit mark, zero and one space, tolerances)
  - a function converting microseconds to ticks
  - frame length constant 32
- One sub-module, ir_tick_gen: clk/rst in, tick out, parameterized by TICK_DIV.

Test Plan:
- Frame 0xFE010707 with nominal timing, ack held low → command=0xFE010707; ir_ready=1, 3 clks after the stop edge; busy returns to 0.
- Ack handshake: with ir_ready=1, raise ack for 4 ms then drop it, then send 0x9F600707 → ir_ready clears within 3 clks of ack rising; second frame loads command=0x9F600707.
- Overrun: ir_ready=1 with no ack, send 0xED120707 → overrun pulses once; command stays at the old value; no frame_err.
- Timeout and malformed input:
  - 4.5 ms leader, then a 1000 µs bit space → frame_err pulse, then IDLE.
  - Line held as mark for 10 ms → frame_err at 7 ms.
  - Following good frame 0x97680707 decodes correctly.
- Reset mid-frame: assert rst after 12 bits → all outputs 0 immediately; no frame_err after release; next frame decodes.
- IR_CHECK_EN: send 0xFE000707 → frame_err with macro defined and ir_ready stays 0; accepted with command=0xFE000707 when undefined.

Source files
------------

// File: rtl/ir_frame_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ir_pkg
// Description : Shared types and timing constants for the Samsung-format IR
//               frame decoder: FSM state encoding, pulse-window limits in
//               microseconds, microsecond-to-tick conversion, frame length.
// Revision    : 1.0 - initial release
// ============================================================================
package ir_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LEAD_MARK  = 3'd1,
        S_LEAD_SPACE = 3'd2,
        S_BIT_MARK   = 3'd3,
        S_BIT_SPACE  = 3'd4,
        S_STOP_MARK  = 3'd5,
        S_DONE       = 3'd6
    } state_e;

    localparam int FRAME_BITS = 32;

    // Leader mark and leader space: 4500 us nominal, +/-900 us.
    localparam int LEAD_MIN_US = 3600;
    localparam int LEAD_MAX_US = 5400;
    // Bit mark, stop mark and zero space: ~560 us nominal, wide tolerance.
    localparam int BIT_MIN_US  = 300;
    localparam int BIT_MAX_US  = 900;
    // One space: 1690 us nominal.
    localparam int ONE_MIN_US  = 1200;
    localparam int ONE_MAX_US  = 2300;

    function automatic int us_to_ticks(input int us, input int tick_us);
        return us / tick_us;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ir_frame_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : ir_frame_decoder_if
// Description : Command handshake between the IR decoder (master, producer
//               of command/ir_ready and status pulses) and the cart control
//               logic (slave, producer of ack).
// Ports       : command[31:0], ir_ready, frame_err, overrun, busy, ack
// Revision    : 1.0 - initial release
// ============================================================================
interface ir_frame_decoder_if;
    logic [31:0] command;
    logic        ir_ready;
    logic        frame_err;
    logic        overrun;
    logic        busy;
    logic        ack;

    modport master (
        output command, ir_ready, frame_err, overrun, busy,
        input  ack
    );

    modport slave (
        input  command, ir_ready, frame_err, overrun, busy,
        output ack
    );
endinterface
`default_nettype wire

// File: rtl/ir_frame_decoder_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : ir_tick_gen
// Description : Free-running divider producing a one-clk tick every TICK_DIV
//               clocks (tick is high every clock when TICK_DIV = 1).
// Ports       : clk, rst (async, active-high), tick (out)
// Revision    : 1.0 - initial release
// ============================================================================
module ir_tick_gen #(
    parameter int TICK_DIV = 250
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule
`default_nettype wire

// File: rtl/ir_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ir_frame_decoder
// Description : Decodes Samsung-format IR frames (leader, 32 data bits
//               LSB-first, stop mark) into a 32-bit command word presented
//               with a ready/ack handshake to a slow-clocked consumer.
// Ports       : clk, rst (async, active-high), ir_in (async pin),
//               bus (master): command, ir_ready, frame_err, overrun, busy,
//               ack (async level)
// Options     : IR_CHECK_EN - require byte[23:16] == ~byte[31:24]
// Revision    : 1.0 - initial release
// ============================================================================
module ir_frame_decoder
    import ir_pkg::*;
#(
    parameter int CLK_HZ        = 25000000,
    parameter int TICK_US       = 10,
    parameter bit IR_ACTIVE_LOW = 1'b1,
    parameter int TIMEOUT_TICKS = 700
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ir_in,
    ir_frame_decoder_if.master bus
);
    localparam int TICK_RAW = CLK_HZ * TICK_US / 1000000;
    localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int SW       = $clog2(TIMEOUT_TICKS + 1);
    localparam int BW       = $clog2(FRAME_BITS);

    typedef logic [SW-1:0] seg_t;

    localparam seg_t T_TIMEOUT  = seg_t'(TIMEOUT_TICKS);
    localparam seg_t T_LEAD_MIN = seg_t'(us_to_ticks(LEAD_MIN_US, TICK_US));
    localparam seg_t T_LEAD_MAX = seg_t'(us_to_ticks(LEAD_MAX_US, TICK_US));
    localparam seg_t T_BIT_MIN  = seg_t'(us_to_ticks(BIT_MIN_US, TICK_US));
    localparam seg_t T_BIT_MAX  = seg_t'(us_to_ticks(BIT_MAX_US, TICK_US));
    localparam seg_t T_ONE_MIN  = seg_t'(us_to_ticks(ONE_MIN_US, TICK_US));
    localparam seg_t T_ONE_MAX  = seg_t'(us_to_ticks(ONE_MAX_US, TICK_US));

    function automatic logic in_win(input seg_t v, input seg_t lo, input seg_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

    logic tick;

    ir_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Synchronizers reset to the idle pin level so no edge is seen on release.
    logic ir_s1_q, ir_s1_d, ir_s2_q, ir_s2_d;
    logic ack_s1_q, ack_s1_d, ack_s2_q, ack_s2_d;
    logic mark_prev_q, mark_prev_d;
    seg_t seg_q, seg_d;

    logic mark, rise, fall;

    assign mark = ir_s2_q ^ IR_ACTIVE_LOW;
    assign rise = mark & ~mark_prev_q;
    assign fall = ~mark & mark_prev_q;

    always_comb begin
        ir_s1_d     = ir_in;
        ir_s2_d     = ir_s1_q;
        ack_s1_d    = bus.ack;
        ack_s2_d    = ack_s1_q;
        mark_prev_d = mark;
        seg_d       = seg_q;
        if (mark != mark_prev_q)
            seg_d = '0;
        else if (tick && (seg_q != T_TIMEOUT))
            seg_d = seg_q + seg_t'(1);
    end

    state_e          state_q, state_d;
    logic [BW-1:0]   bitcnt_q, bitcnt_d;
    logic [31:0]     sr_q, sr_d;
    logic [31:0]     command_q, command_d;
    logic            ir_ready_q, ir_ready_d;
    logic            ack_seen_q, ack_seen_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            err;
    logic            can_load;

    // A new word may only be presented once the previous one was acked
    // and ack has dropped again.
    assign can_load = ~ir_ready_q & ~ack_seen_q & ~ack_s2_q;

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        sr_d        = sr_q;
        command_d   = command_q;
        ir_ready_d  = ir_ready_q;
        ack_seen_d  = ack_s2_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        err         = 1'b0;

        if (ack_s2_q)
            ir_ready_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d  = S_LEAD_MARK;
                    bitcnt_d = '0;
                    sr_d     = '0;
                end
            end
            S_LEAD_MARK: begin
                if (fall) begin
                    if (in_win(seg_q, T_LEAD_MIN, T_LEAD_MAX)) state_d = S_LEAD_SPACE;
                    else err = 1'b1;
                end
            end
            S_LEAD_SPACE: begin
                if (rise) begin
                    if (in_win(seg_q, T_LEAD_MIN, T_LEAD_MAX)) state_d = S_BIT_MARK;
                    else err = 1'b1;
                end
            end
            S_BIT_MARK: begin
                if (fall) begin
                    if (in_win(seg_q, T_BIT_MIN, T_BIT_MAX)) state_d = S_BIT_SPACE;
                    else err = 1'b1;
                end
            end
            S_BIT_SPACE: begin
                if (rise) begin
                    if (in_win(seg_q, T_BIT_MIN, T_BIT_MAX))
                        sr_d[bitcnt_q] = 1'b0;
                    else if (in_win(seg_q, T_ONE_MIN, T_ONE_MAX))
                        sr_d[bitcnt_q] = 1'b1;
                    else
                        err = 1'b1;
                    if (!err) begin
                        if (bitcnt_q == BW'(FRAME_BITS - 1)) begin
                            state_d = S_STOP_MARK;
                        end else begin
                            bitcnt_d = bitcnt_q + BW'(1);
                            state_d  = S_BIT_MARK;
                        end
                    end
                end
            end
            S_STOP_MARK: begin
                if (fall) begin
                    if (in_win(seg_q, T_BIT_MIN, T_BIT_MAX)) state_d = S_DONE;
                    else err = 1'b1;
                end
            end
            S_DONE: begin
`ifdef IR_CHECK_EN
                if (sr_q[23:16] != ~sr_q[31:24]) begin
                    frame_err_d = 1'b1;
                end else if (can_load) begin
                    command_d  = sr_q;
                    ir_ready_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
`else
                if (can_load) begin
                    command_d  = sr_q;
                    ir_ready_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
`endif
                state_d  = S_IDLE;
                bitcnt_d = '0;
                sr_d     = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // Saturation is only an abort inside a frame; IDLE sits saturated.
        if ((state_q != S_IDLE) && (state_q != S_DONE) && (seg_q == T_TIMEOUT))
            err = 1'b1;

        if (err) begin
            frame_err_d = 1'b1;
            sr_d        = '0;
            bitcnt_d    = '0;
            state_d     = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_s1_q     <= IR_ACTIVE_LOW;
            ir_s2_q     <= IR_ACTIVE_LOW;
            ack_s1_q    <= 1'b0;
            ack_s2_q    <= 1'b0;
            mark_prev_q <= 1'b0;
            seg_q       <= '0;
            state_q     <= S_IDLE;
            bitcnt_q    <= '0;
            sr_q        <= '0;
            command_q   <= '0;
            ir_ready_q  <= 1'b0;
            ack_seen_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            ir_s1_q     <= ir_s1_d;
            ir_s2_q     <= ir_s2_d;
            ack_s1_q    <= ack_s1_d;
            ack_s2_q    <= ack_s2_d;
            mark_prev_q <= mark_prev_d;
            seg_q       <= seg_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            sr_q        <= sr_d;
            command_q   <= command_d;
            ir_ready_q  <= ir_ready_d;
            ack_seen_q  <= ack_seen_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.command   = command_q;
    assign bus.ir_ready  = ir_ready_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule
`default_nettype wire
